// File: rtl/channel.sv
// channel: single-sender / multi-receiver broadcast handshake channel.
//
// A token fires when the channel is IDLE, the sender offers (s_valid) and
// every receiver requests (r_ready) in the same cycle. The payload is
// latched into r_data, and sender/receiver "done" flags rise one cycle later.
//   PHASE=2 : pulse protocol. DONE lasts one cycle, then the channel is IDLE again.
//   PHASE=4 : return-to-zero. Each done holds until its own request falls.
//             The channel returns to IDLE once every request is low (RTZ state).
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   s_valid, s_data     sender offer and payload
//   s_done              sender-side completion
//   r_ready[N]          per-receiver request
//   r_done[N]           per-receiver completion
//   r_data              latched payload (held between transfers)
//   data0, data1        dual-rail image of r_data (all-zero when IDLE)
//   status              0 idle, 1 send pending, 2 receive pending, 3 transferring
//   p1of4               (only with `define CHANNEL_P1OF4_EN) 1-of-4 image of r_data

// One completion flag. Set on fire. In the return-to-zero protocol it holds
// while its request stays high.
module channel_done_lane #(
  parameter int PHASE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic req,
  output logic done
);
  localparam bit HOLD = (PHASE == 4);

  logic done_d, done_q;

  always_comb begin
    done_d = fire | (HOLD & done_q & req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done = done_q;
endmodule

module channel #(
  parameter int WIDTH               = 8,
  parameter int NUMBER_OF_RECEIVERS = 1,
  parameter int PHASE               = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  input  logic [WIDTH-1:0]               s_data,
  output logic                           s_done,
  input  logic [NUMBER_OF_RECEIVERS-1:0] r_ready,
  output logic [NUMBER_OF_RECEIVERS-1:0] r_done,
  output logic [WIDTH-1:0]               r_data,
  output logic [WIDTH-1:0]               data0,
  output logic [WIDTH-1:0]               data1,
  output logic [1:0]                     status
`ifdef CHANNEL_P1OF4_EN
  ,
  output logic [4*((WIDTH+1)/2)-1:0]     p1of4
`endif
);
  localparam int N = NUMBER_OF_RECEIVERS;

  // Reject illegal configurations at elaboration.
  generate
    if (!(PHASE == 2 || PHASE == 4)) begin : g_bad_phase
      $error("channel: PHASE must be 2 or 4");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("channel: WIDTH must be in 1..64");
    end
    if (N < 1 || N > 8) begin : g_bad_n
      $error("channel: NUMBER_OF_RECEIVERS must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1,
    RTZ  = 2'd2
  } state_e;

  state_e           state_d, state_q;
  logic [WIDTH-1:0] r_data_d, r_data_q;
  logic             fire;
  logic             all_low;
  logic             active;

  assign fire    = (state_q == IDLE) & s_valid & (&r_ready);
  assign all_low = ~s_valid & ~(|r_ready);
  assign active  = (state_q != IDLE);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    r_data_d = r_data_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = DONE;
          r_data_d = s_data;
        end
      end
      DONE: begin
        // The pulse protocol always drops back. In the return-to-zero
        // protocol, the channel waits in RTZ until every request is low.
        if (PHASE == 2 || all_low) state_d = IDLE;
        else                       state_d = RTZ;
      end
      RTZ: begin
        if (all_low) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      r_data_q <= r_data_d;
    end
  end

  // Completion flags: one lane for the sender, and one lane for each receiver.
  channel_done_lane #(.PHASE(PHASE)) u_s_lane (
    .clk  (clk),
    .rst_n(rst_n),
    .fire (fire),
    .req  (s_valid),
    .done (s_done)
  );

  generate
    for (genvar i = 0; i < N; i++) begin : g_r_lane
      channel_done_lane #(.PHASE(PHASE)) u_r_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .fire (fire),
        .req  (r_ready[i]),
        .done (r_done[i])
      );
    end
  endgenerate

  assign r_data = r_data_q;
  assign data1  = active ? r_data_q  : '0;
  assign data0  = active ? ~r_data_q : '0;

  // In IDLE, the status bits are simply {any receiver asking, sender asking}.
  assign status = active ? 2'd3 : {|r_ready, s_valid};

`ifdef CHANNEL_P1OF4_EN
  // Each 2-bit group of r_data selects one rail out of four. An odd top bit
  // is padded with a zero high bit.
  generate
    for (genvar k = 0; k < (WIDTH + 1) / 2; k++) begin : g_p1of4
      logic [1:0] grp;
      if (2 * k + 1 < WIDTH) begin : g_full
        assign grp = r_data_q[2*k+1:2*k];
      end else begin : g_pad
        assign grp = {1'b0, r_data_q[2*k]};
      end
      assign p1of4[4*k +: 4] = active ? (4'b0001 << grp) : 4'b0000;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_channel.sv
// Directed bench for channel: a PHASE=4 instance with two receivers, driven
// from a vector table and hand sequences, plus a PHASE=2 instance with one
// receiver that is checked for pulse spacing.
module tb_channel;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // PHASE=4, two receivers
  logic       sv4 = 1'b0;
  logic [7:0] sd4 = 8'h00;
  logic [1:0] rr4 = 2'b00;
  logic       sdone4;
  logic [1:0] rdone4;
  logic [7:0] rdat4, d0_4, d1_4;
  logic [1:0] st4;

  // PHASE=2, one receiver
  logic       sv2 = 1'b0;
  logic [7:0] sd2 = 8'h00;
  logic [0:0] rr2 = 1'b0;
  logic       sdone2;
  logic [0:0] rdone2;
  logic [7:0] rdat2, d0_2, d1_2;
  logic [1:0] st2;

`ifdef CHANNEL_P1OF4_EN
  logic [15:0] p1_4, p1_2;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  channel #(.WIDTH(8), .NUMBER_OF_RECEIVERS(2), .PHASE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv4), .s_data(sd4), .s_done(sdone4),
    .r_ready(rr4), .r_done(rdone4), .r_data(rdat4), .data0(d0_4), .data1(d1_4),
    .status(st4)
`ifdef CHANNEL_P1OF4_EN
    , .p1of4(p1_4)
`endif
  );

  channel #(.WIDTH(8), .NUMBER_OF_RECEIVERS(1), .PHASE(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv2), .s_data(sd2), .s_done(sdone2),
    .r_ready(rr2), .r_done(rdone2), .r_data(rdat2), .data0(d0_2), .data1(d1_2),
    .status(st2)
`ifdef CHANNEL_P1OF4_EN
    , .p1of4(p1_2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       sv;
    logic [1:0] rr;
    logic [7:0] sd;
    logic       e_sdone;
    logic [1:0] e_rdone;
    logic [7:0] e_rdat;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[14];

  task automatic chk_p4(input string tag, input logic e_sdone, input logic [1:0] e_rdone,
                        input logic [7:0] e_rdat, input logic [7:0] e_d0,
                        input logic [7:0] e_d1, input logic [1:0] e_st);
    chk({tag, ".s_done"}, 64'(sdone4), 64'(e_sdone));
    chk({tag, ".r_done"}, 64'(rdone4), 64'(e_rdone));
    chk({tag, ".r_data"}, 64'(rdat4),  64'(e_rdat));
    chk({tag, ".data0"},  64'(d0_4),   64'(e_d0));
    chk({tag, ".data1"},  64'(d1_4),   64'(e_d1));
    chk({tag, ".status"}, 64'(st4),    64'(e_st));
  endtask

  initial begin
    //          sv   rr     sd     | sdone rdone  rdat   d0     d1     st
    vecs[0]  = '{1'b0, 2'b01, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd2};
    vecs[1]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd3};
    vecs[2]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd3};
    vecs[3]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd3};
    vecs[4]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd3};
    vecs[5]  = '{1'b1, 2'b11, 8'hA5, 1'b1, 2'b11, 8'hA5, 8'h5A, 8'hA5, 2'd3};
    vecs[6]  = '{1'b1, 2'b10, 8'hA5, 1'b1, 2'b10, 8'hA5, 8'h5A, 8'hA5, 2'd3};
    vecs[7]  = '{1'b1, 2'b10, 8'hA5, 1'b1, 2'b10, 8'hA5, 8'h5A, 8'hA5, 2'd3};
    vecs[8]  = '{1'b0, 2'b10, 8'hA5, 1'b0, 2'b10, 8'hA5, 8'h5A, 8'hA5, 2'd3};
    vecs[9]  = '{1'b0, 2'b00, 8'hA5, 1'b0, 2'b00, 8'hA5, 8'h00, 8'h00, 2'd0};
    vecs[10] = '{1'b1, 2'b11, 8'h12, 1'b1, 2'b11, 8'h12, 8'hED, 8'h12, 2'd3};
    vecs[11] = '{1'b0, 2'b00, 8'h12, 1'b0, 2'b00, 8'h12, 8'h00, 8'h00, 2'd0};
    vecs[12] = '{1'b1, 2'b00, 8'h77, 1'b0, 2'b00, 8'h12, 8'h00, 8'h00, 2'd1};
    vecs[13] = '{1'b0, 2'b11, 8'h77, 1'b0, 2'b00, 8'h12, 8'h00, 8'h00, 2'd2};

    // Reset state
    #12;
    chk_p4("reset", 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd0);
    chk("reset.p2_s_done", 64'(sdone2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: apply inputs, take one edge, then check just after it.
    for (int i = 0; i < 14; i++) begin
      sv4 = vecs[i].sv; rr4 = vecs[i].rr; sd4 = vecs[i].sd;
      @(posedge clk); #1;
      chk_p4($sformatf("vec%0d", i), vecs[i].e_sdone, vecs[i].e_rdone,
             vecs[i].e_rdat, vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_st);
    end

    // Reset asserted in DONE aborts at once. After release, the next edge fires again.
    sv4 = 1'b1; rr4 = 2'b11; sd4 = 8'h5A;
    @(posedge clk); #1;
    chk("rst_mid.pre_s_done", 64'(sdone4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_p4("rst_mid.async", 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 2'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_p4("rst_mid.refire", 1'b1, 2'b11, 8'h5A, 8'hA5, 8'h5A, 2'd3);

    sv4 = 1'b0; rr4 = 2'b00;
    @(posedge clk); #1;
    chk_p4("rst_mid.idle", 1'b0, 2'b00, 8'h5A, 8'h00, 8'h00, 2'd0);

`ifdef CHANNEL_P1OF4_EN
    chk("p1of4.idle", 64'(p1_4), 64'd0);
    sv4 = 1'b1; rr4 = 2'b11; sd4 = 8'b11_10_01_00;
    @(posedge clk); #1;
    chk("p1of4.done", 64'(p1_4), 64'(16'b1000_0100_0010_0001));
    sv4 = 1'b0; rr4 = 2'b00;
    @(posedge clk); #1;
    chk("p1of4.back_idle", 64'(p1_4), 64'd0);
`endif

    // PHASE=2: requests held high produce one-cycle pulses every other cycle.
    sv2 = 1'b1; rr2 = 1'b1; sd2 = 8'h03;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("p2.cyc%0d.s_done", i), 64'(sdone2), 64'((i % 2) == 0));
      chk($sformatf("p2.cyc%0d.r_done", i), 64'(rdone2), 64'((i % 2) == 0));
      chk($sformatf("p2.cyc%0d.data1", i),  64'(d1_2),   ((i % 2) == 0) ? 64'h03 : 64'h00);
      chk($sformatf("p2.cyc%0d.status", i), 64'(st2),    64'd3);
    end
    chk("p2.r_data", 64'(rdat2), 64'h03);
    sv2 = 1'b0; rr2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("p2.quiet.s_done", 64'(sdone2), 64'd0);
    chk("p2.quiet.status", 64'(st2), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
